sprite_pixel_arbiter: RTL and testbench

SPRITE_PIXEL_ARBITER -- requirements
Module: sprite_pixel_arbiter

---
 rtl/sprite_pixel_arbiter.sv | 90 +++++++++
 tb/tb_sprite_pixel_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_pixel_arbiter.sv
// sprite_pixel_arbiter: arbitrates two sprite renderers onto a shared ROM/palette with a burst-bounded owner,
// then carries each pixel's owner tag through a fixed 3-cycle fetch pipeline.
module sprite_pixel_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int MAX_BURST = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    output logic              p1_ack,
    output logic              p1_valid,
    input  logic              p2_req,
    input  logic [ADDR_W-1:0] p2_addr,
    output logic              p2_ack,
    output logic              p2_valid,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_index,
    output logic [3:0]        pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [3:0]        rgb_red,
    output logic [3:0]        rgb_green,
    output logic [3:0]        rgb_blue,
    output logic              rgb_transparent
);
    typedef enum logic {OWN_P1, OWN_P2} owner_t;
    localparam logic [7:0] L_MAX = 8'(MAX_BURST);

    owner_t            r_last_owner;
    logic [7:0]        r_burst_cnt;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_v1, r_v2, r_own1, r_own2;
    logic              r_p1_valid, r_p2_valid, r_transp;
    logic [11:0]       r_rgb;
    logic              w_keep, w_p1_win, w_p1_ack, w_p2_ack, w_any, w_to_owner;

    // A non-zero count means the owner was granted last cycle, i.e. its run is unbroken.
    assign w_keep     = (r_burst_cnt != 8'd0) && (r_burst_cnt < L_MAX);
    assign w_p1_win   = (r_last_owner == OWN_P1) ? w_keep : !w_keep;
    assign w_p1_ack   = Reset_n && p1_req && (!p2_req || w_p1_win);
    assign w_p2_ack   = Reset_n && p2_req && (!p1_req || !w_p1_win);
    assign w_any      = w_p1_ack || w_p2_ack;
    assign w_to_owner = (w_p1_ack && r_last_owner == OWN_P1) || (w_p2_ack && r_last_owner == OWN_P2);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_last_owner <= OWN_P2;
            r_burst_cnt  <= 8'd0;
            r_rom_addr   <= '0;
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_own1       <= 1'b0;
            r_own2       <= 1'b0;
            r_p1_valid   <= 1'b0;
            r_p2_valid   <= 1'b0;
            r_rgb        <= 12'd0;
            r_transp     <= 1'b0;
        end else begin
            if (w_any) begin
                r_last_owner <= w_p1_ack ? OWN_P1 : OWN_P2;
                r_rom_addr   <= w_p1_ack ? p1_addr : p2_addr;
            end
            r_burst_cnt <= !w_any ? 8'd0 : !w_to_owner ? 8'd1 :
                           (r_burst_cnt == 8'hFF) ? r_burst_cnt : r_burst_cnt + 8'd1;
            r_v1       <= w_any;
            r_own1     <= w_p2_ack;
            r_v2       <= r_v1;
            r_own2     <= r_own1;
            r_p1_valid <= r_v2 && !r_own2;
            r_p2_valid <= r_v2 && r_own2;
            if (r_v2) begin
                r_rgb    <= {pal_red, pal_green, pal_blue};
                r_transp <= (rom_index == 4'd0);
            end
        end
    end

    assign p1_ack          = w_p1_ack;
    assign p2_ack          = w_p2_ack;
    assign p1_valid        = r_p1_valid;
    assign p2_valid        = r_p2_valid;
    assign rom_addr        = r_rom_addr;
    assign pal_index       = rom_index;
    assign rgb_red         = r_rgb[11:8];
    assign rgb_green       = r_rgb[7:4];
    assign rgb_blue        = r_rgb[3:0];
    assign rgb_transparent = r_transp;
endmodule

// File: tb/tb_sprite_pixel_arbiter.sv
// tb_sprite_pixel_arbiter: directed scenario tests with a behavioural sync ROM and a
// palette of {~idx, idx, ~idx}, so index 0 yields the F0F key colour.
module tb_sprite_pixel_arbiter;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        p1_req = 1'b0, p2_req = 1'b0;
    logic [11:0] p1_addr = 12'd0, p2_addr = 12'd0;
    logic        p1_ack, p2_ack, p1_valid, p2_valid;
    logic [11:0] rom_addr;
    logic [3:0]  rom_index = 4'd0;
    logic [3:0]  pal_index, pal_red, pal_green, pal_blue;
    logic [3:0]  rgb_red, rgb_green, rgb_blue;
    logic        rgb_transparent;
    logic [12:0] w_rgb;
    int          errors = 0;
    int          checks = 0;

    sprite_pixel_arbiter #(.ADDR_W(12), .MAX_BURST(8)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_ack(p1_ack), .p1_valid(p1_valid),
        .p2_req(p2_req), .p2_addr(p2_addr), .p2_ack(p2_ack), .p2_valid(p2_valid),
        .rom_addr(rom_addr), .rom_index(rom_index), .pal_index(pal_index),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .rgb_red(rgb_red), .rgb_green(rgb_green), .rgb_blue(rgb_blue),
        .rgb_transparent(rgb_transparent)
    );

    always #5 Clk = ~Clk;

    function automatic logic [3:0] rom_f(input logic [11:0] a);
        return (a == 12'h020) ? 4'h0 : (a[3:0] ^ 4'h9);
    endfunction

    function automatic logic [12:0] pix(input logic [11:0] a);
        logic [3:0] i;
        i = rom_f(a);
        return {i == 4'd0, ~i, i, ~i};
    endfunction

    always @(posedge Clk) rom_index <= rom_f(rom_addr);
    assign pal_red   = ~pal_index;
    assign pal_green = pal_index;
    assign pal_blue  = ~pal_index;
    assign w_rgb     = {rgb_transparent, rgb_red, rgb_green, rgb_blue};

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        Reset_n = 1'b0;
        p1_req = 1'b1;
        p2_req = 1'b1;
        tick();
        tick();
        checks++;
        if ({p1_ack, p2_ack, p1_valid, p2_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0000", {p1_ack, p2_ack, p1_valid, p2_valid});
        end
        checks++;
        if ({rom_addr, w_rgb} !== 25'd0) begin
            errors++;
            $display("FAIL reset_data got addr=%h rgb=%h exp 0", rom_addr, w_rgb);
        end
        p1_req = 1'b0;
        p2_req = 1'b0;
        Reset_n = 1'b1;
    endtask

    task automatic test_p1_only;
        for (int c = 0; c < 8; c++) begin
            p1_req = (c < 4);
            p1_addr = 12'h010 + 12'(c);
            p2_req = 1'b0;
            #1;
            checks++;
            if ({p1_ack, p2_ack} !== {c < 4, 1'b0}) begin
                errors++;
                $display("FAIL p1only_ack c=%0d got %b%b exp %b0", c, p1_ack, p2_ack, c < 4);
            end
            checks++;
            if ({p1_valid, p2_valid} !== {(c >= 3 && c <= 6), 1'b0}) begin
                errors++;
                $display("FAIL p1only_valid c=%0d got %b%b exp %b0", c, p1_valid, p2_valid, (c >= 3 && c <= 6));
            end
            if (c >= 3 && c <= 6) begin
                checks++;
                if (w_rgb !== pix(12'h010 + 12'(c - 3))) begin
                    errors++;
                    $display("FAIL p1only_rgb c=%0d got %h exp %h", c, w_rgb, pix(12'h010 + 12'(c - 3)));
                end
            end
            if (c == 1) begin
                checks++;
                if (rom_addr !== 12'h010) begin
                    errors++;
                    $display("FAIL p1only_rom_addr got %h exp 010", rom_addr);
                end
            end
            tick();
        end
    endtask

    task automatic test_transparent;
        for (int c = 0; c < 5; c++) begin
            p2_req = (c == 0);
            p2_addr = 12'h020;
            #1;
            if (c == 0) begin
                checks++;
                if ({p1_ack, p2_ack} !== 2'b01) begin
                    errors++;
                    $display("FAIL transp_ack got %b%b exp 01", p1_ack, p2_ack);
                end
            end
            if (c >= 3) begin
                checks++;
                if ({p1_valid, p2_valid, w_rgb} !== {1'b0, c == 3, 1'b1, 12'hF0F}) begin
                    errors++;
                    $display("FAIL transp_pixel c=%0d got v=%b%b rgb=%h exp v=0%b rgb=1f0f", c, p1_valid, p2_valid, w_rgb, c == 3);
                end
            end
            tick();
        end
    endtask

    task automatic test_bubbles;
        for (int c = 0; c < 8; c++) begin
            p1_req = (c == 0 || c == 3);
            p1_addr = (c < 3) ? 12'h013 : 12'h015;
            #1;
            checks++;
            if (p1_ack !== (c == 0 || c == 3)) begin
                errors++;
                $display("FAIL bubble_ack c=%0d got %b exp %b", c, p1_ack, (c == 0 || c == 3));
            end
            if (c >= 3) begin
                checks++;
                if (p1_valid !== (c == 3 || c == 6)) begin
                    errors++;
                    $display("FAIL bubble_valid c=%0d got %b exp %b", c, p1_valid, (c == 3 || c == 6));
                end
                checks++;
                if (w_rgb !== pix(c < 6 ? 12'h013 : 12'h015)) begin
                    errors++;
                    $display("FAIL bubble_rgb c=%0d got %h exp %h", c, w_rgb, pix(c < 6 ? 12'h013 : 12'h015));
                end
            end
            if (c == 2 || c == 3) begin
                checks++;
                if (rom_addr !== 12'h013) begin
                    errors++;
                    $display("FAIL bubble_rom_hold c=%0d got %h exp 013", c, rom_addr);
                end
            end
            tick();
        end
    endtask

    // Contended 8-cycle runs, then P2 alone past the burst limit, then contention hands over to P1.
    task automatic test_burst;
        logic exp_h [0:36];
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        p1_addr = 12'h101;
        p2_addr = 12'h202;
        for (int c = 0; c < 37; c++) begin
            p1_req = (c < 24 || c == 36);
            p2_req = 1'b1;
            exp_h[c] = (c < 24) ? ((c / 8) % 2 == 0) : (c == 36);
            #1;
            checks++;
            if ({p1_ack, p2_ack} !== {exp_h[c], !exp_h[c]}) begin
                errors++;
                $display("FAIL burst_ack c=%0d got %b%b exp %b%b", c, p1_ack, p2_ack, exp_h[c], !exp_h[c]);
            end
            if (c >= 3) begin
                checks++;
                if ({p1_valid, p2_valid, rgb_green} !== {exp_h[c-3], !exp_h[c-3], exp_h[c-3] ? 4'h8 : 4'hB}) begin
                    errors++;
                    $display("FAIL burst_pixel c=%0d got v=%b%b g=%h exp v=%b%b g=%h", c, p1_valid, p2_valid, rgb_green,
                             exp_h[c-3], !exp_h[c-3], exp_h[c-3] ? 4'h8 : 4'hB);
                end
            end
            tick();
        end
        p1_req = 1'b0;
        p2_req = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_gap_contend;
        logic e1, e2;
        p1_addr = 12'h101;
        p2_addr = 12'h202;
        for (int c = 0; c < 12; c++) begin
            p1_req = (c == 0 || c >= 2);
            p2_req = (c >= 2);
            e1 = (c == 0 || c >= 10);
            e2 = (c >= 2 && c <= 9);
            #1;
            checks++;
            if ({p1_ack, p2_ack} !== {e1, e2}) begin
                errors++;
                $display("FAIL gap_ack c=%0d got %b%b exp %b%b", c, p1_ack, p2_ack, e1, e2);
            end
            tick();
        end
        p1_req = 1'b0;
        p2_req = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset_mid;
        for (int c = 0; c < 7; c++) begin
            p1_req = (c <= 3);
            p2_req = (c == 3);
            p1_addr = (c < 3) ? 12'h011 + 12'(c) : 12'h016;
            if (c == 3) Reset_n = 1'b1;
            #1;
            if (c <= 3) begin
                checks++;
                if ({p1_ack, p2_ack} !== 2'b10) begin
                    errors++;
                    $display("FAIL rstmid_ack c=%0d got %b%b exp 10", c, p1_ack, p2_ack);
                end
            end
            if (c >= 3) begin
                checks++;
                if ({p1_valid, p2_valid, w_rgb} !== ((c == 6) ? {2'b10, pix(12'h016)} : 15'd0)) begin
                    errors++;
                    $display("FAIL rstmid_out c=%0d got v=%b%b rgb=%h exp v=%b0", c, p1_valid, p2_valid, w_rgb, c == 6);
                end
            end
            if (c == 2) begin
                Reset_n = 1'b0;
                #1;
                checks++;
                if ({p1_ack, p2_ack, p1_valid, p2_valid, rom_addr, w_rgb} !== 29'd0) begin
                    errors++;
                    $display("FAIL rstmid_clear got ack=%b%b v=%b%b addr=%h rgb=%h exp 0", p1_ack, p2_ack,
                             p1_valid, p2_valid, rom_addr, w_rgb);
                end
            end
            tick();
        end
        p1_req = 1'b0;
        p2_req = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_p1_only();
        test_transparent();
        test_bubbles();
        test_burst();
        test_gap_contend();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
